mem_bus_arbiter: RTL

//  Shares one single-ported memory bus between the instruction-fetch port and the data (load/store) port of the 5-stage CPU.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU fetch/data ports, the arbiter and the memory controller.
// The master modport is the arbiter's view; slave is the CPU + memory side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_valid;

    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic [DATA_W-1:0] d_rd_data;
    logic              d_valid;
    logic              err;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic              bus_rd;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_ack;

    modport master (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wr_data, bus_rd_data, bus_ack,
        output if_data, if_valid, d_rd_data, d_valid, err,
               bus_addr, bus_wr_data, bus_rd, bus_wr
    );

    modport slave (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wr_data, bus_rd_data, bus_ack,
        input  if_data, if_valid, d_rd_data, d_valid, err,
               bus_addr, bus_wr_data, bus_rd, bus_wr
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between the fetch and data ports; data has priority,
// a streak limit bounds fetch starvation, a watchdog aborts hung transactions.
// Optional performance counters: define MEM_ARB_PERF_CNT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_STREAK  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    mem_bus_arbiter_if.master arb
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_wait_cycles
`endif
);

    localparam int WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wr_data;
    logic              r_bus_rd;
    logic              r_bus_wr;
    logic [DATA_W-1:0] r_if_data;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_d_rd_data;
    logic              r_d_valid;
    logic              r_err;
    logic [3:0]        r_streak;
    logic [WDOG_W-1:0] r_wdog;

    logic w_if_pend;
    logic w_d_pend;
    logic w_grant_d;
    logic w_grant_i;
    logic w_timeout;
    logic w_done;

    // A port whose valid pulse is high this cycle still shows its old request; ignore it.
    assign w_if_pend = arb.if_req & ~r_if_valid;
    assign w_d_pend  = (arb.d_rd | arb.d_wr) & ~r_d_valid;

    assign w_grant_d = (r_state == ST_IDLE) & w_d_pend &
                       ((r_streak < 4'(MAX_STREAK)) | ~w_if_pend);
    assign w_grant_i = (r_state == ST_IDLE) & ~w_grant_d & w_if_pend;

    assign w_timeout = (TIMEOUT_CYC != 0) && !arb.bus_ack &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));
    assign w_done    = arb.bus_ack | w_timeout;

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_bus_rd      <= 1'b0;
            r_bus_wr      <= 1'b0;
            r_if_data     <= '0;
            r_if_valid    <= 1'b0;
            r_d_rd_data   <= '0;
            r_d_valid     <= 1'b0;
            r_err         <= 1'b0;
            r_streak      <= '0;
            r_wdog        <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state       <= ST_DATA;
                        r_bus_addr    <= arb.d_addr;
                        r_bus_wr_data <= arb.d_wr_data;
                        r_bus_wr      <= arb.d_wr;
                        r_bus_rd      <= ~arb.d_wr;
                        r_wdog        <= '0;
                        if (r_streak < 4'(MAX_STREAK)) begin
                            r_streak <= r_streak + 4'd1;
                        end
                    end else if (w_grant_i) begin
                        r_state       <= ST_INSTR;
                        r_bus_addr    <= arb.if_addr;
                        r_bus_wr_data <= '0;
                        r_bus_rd      <= 1'b1;
                        r_bus_wr      <= 1'b0;
                        r_wdog        <= '0;
                        r_streak      <= '0;
                    end
                end

                ST_INSTR, ST_DATA: begin
                    if (w_done) begin
                        r_state  <= ST_IDLE;
                        r_bus_rd <= 1'b0;
                        r_bus_wr <= 1'b0;
                        r_err    <= w_timeout;
                        if (r_state == ST_INSTR) begin
                            r_if_valid <= 1'b1;
                            r_if_data  <= arb.bus_ack ? arb.bus_rd_data : '0;
                        end else begin
                            r_d_valid   <= 1'b1;
                            r_d_rd_data <= (arb.bus_ack && r_bus_rd) ? arb.bus_rd_data : '0;
                        end
                    end else if (TIMEOUT_CYC != 0) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign arb.bus_addr    = r_bus_addr;
    assign arb.bus_wr_data = r_bus_wr_data;
    assign arb.bus_rd      = r_bus_rd;
    assign arb.bus_wr      = r_bus_wr;
    assign arb.if_data     = r_if_data;
    assign arb.if_valid    = r_if_valid;
    assign arb.d_rd_data   = r_d_rd_data;
    assign arb.d_valid     = r_d_valid;
    assign arb.err         = r_err;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_if_grants;
    logic [31:0] r_perf_d_grants;
    logic [31:0] r_perf_wait_cycles;
    logic        w_if_served;
    logic        w_d_served;
    logic        w_wait;

    // A request counts as waiting unless its transaction is on the bus or being granted now.
    assign w_if_served = (r_state == ST_INSTR) | w_grant_i;
    assign w_d_served  = (r_state == ST_DATA) | w_grant_d;
    assign w_wait      = (w_if_pend & ~w_if_served) | (w_d_pend & ~w_d_served);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_if_grants   <= '0;
            r_perf_d_grants    <= '0;
            r_perf_wait_cycles <= '0;
        end else begin
            if (w_grant_i) r_perf_if_grants <= r_perf_if_grants + 32'd1;
            if (w_grant_d) r_perf_d_grants <= r_perf_d_grants + 32'd1;
            if (w_wait)    r_perf_wait_cycles <= r_perf_wait_cycles + 32'd1;
        end
    end

    assign perf_if_grants   = r_perf_if_grants;
    assign perf_d_grants    = r_perf_d_grants;
    assign perf_wait_cycles = r_perf_wait_cycles;
`endif

endmodule
